hilo_mult_unit: RTL

//  Multi-cycle 32x32 multiplier owning the HI/LO register pair for MULT/MULTU.

---
 rtl/hilo_mult_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hilo_mult_unit.sv
// Multi-cycle radix-2 shift-add multiplier that owns the HI/LO pair for MULT/MULTU.
// Operands are reduced to magnitudes on accept and the product sign is fixed at completion.
module hilo_mult_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept_c;
    logic             last_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c;
    logic [PW-1:0]    acc_sum_c;
    logic [PW-1:0]    prod_c;

    assign accept_c  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_c    = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));
    // Magnitude of the most negative value stays representable as an unsigned WIDTH-bit number
    assign abs_a_c   = (is_signed && a[WIDTH-1]) ? WIDTH'(~a + WIDTH'(1)) : a;
    assign abs_b_c   = (is_signed && b[WIDTH-1]) ? WIDTH'(~b + WIDTH'(1)) : b;
    assign acc_sum_c = mplier_q[0] ? PW'(acc_q + mcand_q) : acc_q;
    assign prod_c    = neg_q ? PW'(~acc_sum_c + PW'(1)) : acc_sum_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_c) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and status flags; status is registered from the upcoming state
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        busy_d   = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);

        if (accept_c) begin
            acc_d    = '0;
            mcand_d  = PW'(abs_a_c);
            mplier_d = abs_b_c;
            cnt_d    = '0;
            neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state_q == S_RUN) begin
            acc_d    = acc_sum_c;
            mcand_d  = PW'(mcand_q << 1);
            mplier_d = WIDTH'(mplier_q >> 1);
            cnt_d    = CW'(cnt_q + CW'(1));
            if (last_c) begin
                hi_d = prod_c[PW-1:WIDTH];
                lo_d = prod_c[WIDTH-1:0];
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
